// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and constants for the memory port sequencer
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_ISSUE,
    S_I_WAIT,
    S_D_RD_ISSUE,
    S_D_RD_WAIT,
    S_D_WR_ISSUE,
    S_ERR
  } seq_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] DEFAULT_IDLE_FUNCT3 = F3_W;

  // States in which the captured data-side funct3 is presented to memory
  function automatic logic is_d_state(input seq_state_t s);
    return (s == S_D_RD_ISSUE) || (s == S_D_RD_WAIT) || (s == S_D_WR_ISSUE);
  endfunction

endpackage

// File: rtl/mem_seq_align_check.sv
// rtl/mem_seq_align_check.sv - combinational misalignment detector for fetch and load/store requests
module mem_seq_align_check
  import mem_seq_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr,
  input  logic       is_fetch,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    if (is_fetch) begin
      misaligned = (addr != 2'b00);
    end else begin
      case (funct3)
        F3_W:        misaligned = (addr != 2'b00);
        F3_H, F3_HU: misaligned = addr[0];
        default:     misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// rtl/mem_port_sequencer.sv - arbitrates fetch and load/store requests onto the shared memory block
// Optional misalignment trapping is enabled by defining MEM_SEQ_ALIGN_CHECK_EN.
module mem_port_sequencer
  import mem_seq_pkg::*;
#(
  parameter bit         DATA_PRIORITY = 1'b1,
  parameter logic [2:0] IDLE_FUNCT3   = DEFAULT_IDLE_FUNCT3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [2:0]  d_req_funct3,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data_out,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_data_in,
  input  logic [31:0] dmem_data_out,
  output logic        dmem_wren,
  output logic [2:0]  funct3
);

  seq_state_t  state;
  logic [31:0] i_addr_q;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic [2:0]  d_funct3_q;
  logic        idle;
  logic        i_acc;
  logic        d_acc;

  assign idle = (state == S_IDLE);

  // The losing requester only sees ready drop when the winner is actually asking
  assign i_req_ready = idle && !(DATA_PRIORITY && d_req_valid);
  assign d_req_ready = idle && !(!DATA_PRIORITY && i_req_valid);
  assign i_acc       = i_req_valid && i_req_ready;
  assign d_acc       = d_req_valid && d_req_ready;

  assign imem_address = i_addr_q;
  assign dmem_address = d_addr_q;
  assign dmem_data_in = d_wdata_q;
  assign dmem_wren    = (state == S_D_WR_ISSUE);
  assign funct3       = is_d_state(state) ? d_funct3_q : IDLE_FUNCT3;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic i_mis;
  logic d_mis;
  logic err_is_fetch;

  mem_seq_align_check u_i_align (
    .funct3     (F3_W),
    .addr       (i_req_addr[1:0]),
    .is_fetch   (1'b1),
    .misaligned (i_mis)
  );

  mem_seq_align_check u_d_align (
    .funct3     (d_req_funct3),
    .addr       (d_req_addr[1:0]),
    .is_fetch   (1'b0),
    .misaligned (d_mis)
  );
`else
  assign i_rsp_err = 1'b0;
  assign d_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      i_addr_q    <= 32'h0;
      d_addr_q    <= 32'h0;
      d_wdata_q   <= 32'h0;
      d_funct3_q  <= IDLE_FUNCT3;
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= 32'h0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= 32'h0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
      i_rsp_err    <= 1'b0;
      d_rsp_err    <= 1'b0;
      err_is_fetch <= 1'b0;
`endif
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_acc) begin
`ifdef MEM_SEQ_ALIGN_CHECK_EN
            if (i_mis) begin
              err_is_fetch <= 1'b1;
              state        <= S_ERR;
            end else
`endif
            begin
              i_addr_q <= i_req_addr;
              state    <= S_I_ISSUE;
            end
          end else if (d_acc) begin
`ifdef MEM_SEQ_ALIGN_CHECK_EN
            if (d_mis) begin
              err_is_fetch <= 1'b0;
              state        <= S_ERR;
            end else
`endif
            begin
              d_addr_q   <= d_req_addr;
              d_wdata_q  <= d_req_wdata;
              d_funct3_q <= d_req_funct3;
              state      <= d_req_we ? S_D_WR_ISSUE : S_D_RD_ISSUE;
            end
          end
        end
        S_I_ISSUE:    state <= S_I_WAIT;
        S_I_WAIT: begin
          // Memory sampled the address on the previous edge; its read data is valid now
          i_rsp_valid <= 1'b1;
          i_rsp_data  <= imem_data_out;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
          i_rsp_err   <= 1'b0;
`endif
          state       <= S_IDLE;
        end
        S_D_RD_ISSUE: state <= S_D_RD_WAIT;
        S_D_RD_WAIT: begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= dmem_data_out;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
          d_rsp_err   <= 1'b0;
`endif
          state       <= S_IDLE;
        end
        S_D_WR_ISSUE: begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= 32'h0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
          d_rsp_err   <= 1'b0;
`endif
          state       <= S_IDLE;
        end
`ifdef MEM_SEQ_ALIGN_CHECK_EN
        S_ERR: begin
          if (err_is_fetch) begin
            i_rsp_valid <= 1'b1;
            i_rsp_data  <= 32'h0;
            i_rsp_err   <= 1'b1;
          end else begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= 32'h0;
            d_rsp_err   <= 1'b1;
          end
          state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb/tb_mem_port_sequencer.sv - directed scoreboard bench for mem_port_sequencer
module tb_mem_port_sequencer;
  import mem_seq_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [3:0]  lat;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [2:0]  d_req_funct3;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [31:0] imem_address, imem_data_out, dmem_address, dmem_data_in, dmem_data_out;
  logic        dmem_wren;
  logic [2:0]  funct3;

  logic        i_req_valid_b, i_req_ready_b, i_rsp_valid_b, i_rsp_err_b;
  logic        d_req_valid_b, d_req_ready_b, d_rsp_valid_b, d_rsp_err_b;
  logic [31:0] i_rsp_data_b, d_rsp_data_b;
  logic [31:0] imem_address_b, dmem_address_b, dmem_data_in_b;
  logic        dmem_wren_b;
  logic [2:0]  funct3_b;
  logic [31:0] zero_word = 32'h0;

  mem_port_sequencer #(.DATA_PRIORITY(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .imem_address(imem_address), .imem_data_out(imem_data_out),
    .dmem_address(dmem_address), .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .dmem_wren(dmem_wren), .funct3(funct3)
  );

  mem_port_sequencer #(.DATA_PRIORITY(1'b0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid_b), .i_req_ready(i_req_ready_b), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid_b), .i_rsp_data(i_rsp_data_b), .i_rsp_err(i_rsp_err_b),
    .d_req_valid(d_req_valid_b), .d_req_ready(d_req_ready_b), .d_req_we(d_req_we),
    .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid_b), .d_rsp_data(d_rsp_data_b), .d_rsp_err(d_rsp_err_b),
    .imem_address(imem_address_b), .imem_data_out(zero_word),
    .dmem_address(dmem_address_b), .dmem_data_in(dmem_data_in_b), .dmem_data_out(zero_word),
    .dmem_wren(dmem_wren_b), .funct3(funct3_b)
  );

  // Shared memory: synchronous read on both ports, byte-lane writes, load sign handling
  logic [31:0] mem [0:4095] = '{default: 32'h0};

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'h0, b};
      F3_HU:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (f3[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    imem_data_out <= mem[imem_address[13:2]];
    dmem_data_out <= load_fmt(mem[dmem_address[13:2]], dmem_address[1:0], funct3);
    if (dmem_wren)
      mem[dmem_address[13:2]] <= store_merge(mem[dmem_address[13:2]], dmem_address[1:0], funct3, dmem_data_in);
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  sb_t exp_i[$];
  sb_t exp_d[$];
  int  acc_i[$];
  int  acc_d[$];
  sb_t e_i, e_d;
  int  a_i, a_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after posedge, so valid&&ready here is what the next edge accepts
  always @(negedge clk) begin
    if (!reset && i_req_valid && i_req_ready) acc_i.push_back(cyc);
    if (!reset && d_req_valid && d_req_ready) acc_d.push_back(cyc);
  end

  always @(negedge clk) begin
    if (i_rsp_valid) begin
      chk("i_rsp_pending", 32'(exp_i.size() > 0 && acc_i.size() > 0), 32'd1);
      if (exp_i.size() > 0 && acc_i.size() > 0) begin
        e_i = exp_i.pop_front();
        a_i = acc_i.pop_front();
        chk("i_rsp_data", i_rsp_data, e_i.data);
        chk("i_rsp_err", 32'(i_rsp_err), 32'(e_i.err));
        chk("i_rsp_latency", 32'(cyc - a_i - 1), 32'(e_i.lat));
      end
    end
    if (d_rsp_valid) begin
      chk("d_rsp_pending", 32'(exp_d.size() > 0 && acc_d.size() > 0), 32'd1);
      if (exp_d.size() > 0 && acc_d.size() > 0) begin
        e_d = exp_d.pop_front();
        a_d = acc_d.pop_front();
        chk("d_rsp_data", d_rsp_data, e_d.data);
        chk("d_rsp_err", 32'(d_rsp_err), 32'(e_d.err));
        chk("d_rsp_latency", 32'(cyc - a_d - 1), 32'(e_d.lat));
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(i_req_ready), 32'd1);
    exp_i.push_back('{data: exp_data, err: 1'b0, lat: 4'd2});
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_req_addr  = 32'hFFFF_FFF0;
    @(negedge clk);
    chk({tag, "_imem_addr"}, imem_address, addr);
    chk({tag, "_busy_ready"}, 32'(i_req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic dreq(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err, input string tag);
    logic [3:0]  lat;
    logic [31:0] prev_addr;
    lat = (we || exp_err) ? 4'd1 : 4'd2;
    @(posedge clk); #1;
    prev_addr    = dmem_address;
    d_req_valid  = 1'b1;
    d_req_we     = we;
    d_req_funct3 = f3;
    d_req_addr   = addr;
    d_req_wdata  = wdata;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(d_req_ready), 32'd1);
    exp_d.push_back('{data: exp_data, err: exp_err, lat: lat});
    @(posedge clk); #1;
    d_req_valid  = 1'b0;
    d_req_funct3 = 3'b111;
    d_req_addr   = 32'hFFFF_FFFC;
    d_req_wdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    chk({tag, "_wren"}, 32'(dmem_wren), 32'(we && !exp_err));
    chk({tag, "_funct3"}, 32'(funct3), exp_err ? 32'(F3_W) : 32'(f3));
    chk({tag, "_dmem_addr"}, dmem_address, exp_err ? prev_addr : addr);
    if (we && !exp_err) chk({tag, "_wdata"}, dmem_data_in, wdata);
    if (lat == 4'd2) begin
      @(negedge clk);
      chk({tag, "_funct3_hold"}, 32'(funct3), 32'(f3));
      chk({tag, "_wren_rd"}, 32'(dmem_wren), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_funct3_idle"}, 32'(funct3), 32'(F3_W));
    chk({tag, "_wren_idle"}, 32'(dmem_wren), 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (exp_i.size() == 0 && exp_d.size() == 0) break;
    end
    chk({tag, "_drained"}, 32'(exp_i.size() + exp_d.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_funct3 = F3_W; d_req_addr = 32'h0; d_req_wdata = 32'h0;
    i_req_valid_b = 1'b0; d_req_valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_wren", 32'(dmem_wren), 32'd0);
    chk("rst_funct3", 32'(funct3), 32'(F3_W));
    chk("rst_imem_addr", imem_address, 32'h0);
    chk("rst_dmem_addr", dmem_address, 32'h0);
    chk("rst_dmem_data_in", dmem_data_in, 32'h0);
    chk("rst_i_ready", 32'(i_req_ready), 32'd1);
    chk("rst_d_ready", 32'(d_req_ready), 32'd1);
    chk("rst_d_rsp_err", 32'(d_rsp_err), 32'd0);

    dreq(1'b1, F3_W, 32'h0000_0008, 32'h00A0_0093, 32'h0, 1'b0, "sw_8");
    fetch(32'h0000_0008, 32'h00A0_0093, "fetch_8");
    dreq(1'b1, F3_W, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_2000");
    dreq(1'b0, F3_W, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_2000");
    dreq(1'b1, F3_W, 32'h0000_3000, 32'h1234_5680, 32'h0, 1'b0, "sw_3000");
    dreq(1'b0, F3_B, 32'h0000_3000, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_3000");
    dreq(1'b0, F3_BU, 32'h0000_3000, 32'h0, 32'h0000_0080, 1'b0, "lbu_3000");
    drain("basic");

    // Same-cycle tie, data priority
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h8;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_funct3 = F3_W; d_req_addr = 32'h2000;
    @(negedge clk);
    chk("tieA_d_ready", 32'(d_req_ready), 32'd1);
    chk("tieA_i_ready", 32'(i_req_ready), 32'd0);
    exp_d.push_back('{data: 32'hDEAD_BEEF, err: 1'b0, lat: 4'd2});
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    chk("tieA_i_ready_busy", 32'(i_req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("tieA_d_rsp_pulse", 32'(d_rsp_valid), 32'd1);
    chk("tieA_i_ready_on_rsp", 32'(i_req_ready), 32'd1);
    exp_i.push_back('{data: 32'h00A0_0093, err: 1'b0, lat: 4'd2});
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    drain("tieA");

    // Same-cycle tie, fetch priority
    @(posedge clk); #1;
    i_req_valid_b = 1'b1; d_req_valid_b = 1'b1; d_req_we = 1'b1;
    @(negedge clk);
    chk("tieB_i_ready", 32'(i_req_ready_b), 32'd1);
    chk("tieB_d_ready", 32'(d_req_ready_b), 32'd0);
    @(posedge clk); #1;
    i_req_valid_b = 1'b0;
    @(negedge clk);
    chk("tieB_d_ready_busy", 32'(d_req_ready_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("tieB_i_rsp_pulse", 32'(i_rsp_valid_b), 32'd1);
    chk("tieB_d_ready_on_rsp", 32'(d_req_ready_b), 32'd1);
    @(posedge clk); #1;
    d_req_valid_b = 1'b0;
    @(negedge clk);
    chk("tieB_wren", 32'(dmem_wren_b), 32'd1);
    @(negedge clk);
    chk("tieB_d_rsp_pulse", 32'(d_rsp_valid_b), 32'd1);

    // Reset in the middle of a store
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_funct3 = F3_W; d_req_addr = 32'h2000; d_req_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("rstwr_ready", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    chk("rstwr_wren_before", 32'(dmem_wren), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstwr_wren_drop", 32'(dmem_wren), 32'd0);
    chk("rstwr_i_ready", 32'(i_req_ready), 32'd1);
    chk("rstwr_d_ready", 32'(d_req_ready), 32'd1);
    chk("rstwr_d_rsp_data", d_rsp_data, 32'h0);
    acc_d.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    dreq(1'b0, F3_W, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_after_rst");

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    dreq(1'b1, F3_H, 32'h0000_2001, 32'h0000_BEEF, 32'h0, 1'b1, "sh_mis");
    dreq(1'b0, F3_W, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_after_mis");
`else
    dreq(1'b1, F3_H, 32'h0000_2001, 32'h0000_BEEF, 32'h0, 1'b0, "sh_mis");
`endif
    drain("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
